// File: rtl/acc_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : acc_pkg
//  Description : Shared op-code constants and FSM state encoding for the
//                accumulator datapath.
//  Revision    : 1.0 - initial release
// ============================================================================
package acc_pkg;

  localparam logic [2:0] ACC_NOP  = 3'b000;
  localparam logic [2:0] ACC_LDIN = 3'b001;
  localparam logic [2:0] ACC_LDIR = 3'b010;
  localparam logic [2:0] ACC_CLR  = 3'b011;
  localparam logic [2:0] ACC_ADD  = 3'b100;
  localparam logic [2:0] ACC_SUB  = 3'b101;
  localparam logic [2:0] ACC_MUL  = 3'b110;
  localparam logic [2:0] ACC_RSV  = 3'b111;

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_MUL  = 1'b1
  } acc_state_e;

endpackage
`default_nettype wire

// File: rtl/acc_if.sv
`default_nettype none
// ============================================================================
//  Module      : acc_if
//  Description : Controller <-> accumulator bus: start/op request, operands,
//                register A, handshake and status flags.
//  Revision    : 1.0 - initial release
// ============================================================================
interface acc_if #(
  parameter int n = 8
);
  import acc_pkg::*;

  logic         start;
  logic [2:0]   op;
  logic [n-1:0] IROut;
  logic [n-1:0] Input;
  logic [n-1:0] regAOut;
  logic         busy;
  logic         done;
  logic         carry;
  logic         ovf;
  logic         Aeq0;
  logic         Apos;

  // Controller side
  modport master (
    output start, op, IROut, Input,
    input  regAOut, busy, done, carry, ovf, Aeq0, Apos
  );

  // Accumulator side
  modport slave (
    input  start, op, IROut, Input,
    output regAOut, busy, done, carry, ovf, Aeq0, Apos
  );

endinterface
`default_nettype wire

// File: rtl/acc_shift_mul.sv
`default_nettype none
// ============================================================================
//  Module      : acc_shift_mul
//  Description : Iterative unsigned shift-add multiplier, one multiplier bit
//                per cycle. Loaded on start_i; fin_o is high in the cycle the
//                last bit is processed, with the final product on prod_o.
//  Revision    : 1.0 - initial release
// ============================================================================
module acc_shift_mul #(
  parameter int n = 8
) (
  input  wire logic         clk,
  input  wire logic         clearN,
  input  wire logic         start_i,
  input  wire logic [n-1:0] mcand_i,
  input  wire logic [n-1:0] mplr_i,
  output logic      [n-1:0] prod_o,
  output logic              hi_nz_o,
  output logic              fin_o
);
  import acc_pkg::*;

  localparam int CW = $clog2(n);

  logic            active_q;
  logic [CW-1:0]   cnt_q;
  logic [2*n-1:0]  mcand_q;
  logic [n-1:0]    mplr_q;
  logic [2*n-1:0]  prod_q;
  logic [2*n-1:0]  prod_d;

  // Partial product after folding in the current multiplier bit
  always_comb begin
    prod_d = prod_q + (mplr_q[0] ? mcand_q : '0);
  end

  assign prod_o  = prod_d[n-1:0];
  assign hi_nz_o = |prod_d[2*n-1:n];
  assign fin_o   = active_q && (cnt_q == '0);

  // Load operands on start, then shift one multiplier bit per cycle
  always_ff @(posedge clk) begin
    if (!clearN) begin
      active_q <= 1'b0;
      cnt_q    <= '0;
      mcand_q  <= '0;
      mplr_q   <= '0;
      prod_q   <= '0;
    end else if (start_i) begin
      active_q <= 1'b1;
      cnt_q    <= CW'(n - 1);
      mcand_q  <= {{n{1'b0}}, mcand_i};
      mplr_q   <= mplr_i;
      prod_q   <= '0;
    end else if (active_q) begin
      prod_q  <= prod_d;
      mcand_q <= mcand_q << 1;
      mplr_q  <= mplr_q >> 1;
      cnt_q   <= cnt_q - 1'b1;
      if (cnt_q == '0) begin
        active_q <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/accumulator_unit.sv
`default_nettype none
// ============================================================================
//  Module      : accumulator_unit
//  Description : Register A with load/clear/add/sub in one cycle and a
//                start/busy/done handshake. Define ACC_MUL_EN to build the
//                multi-cycle shift-add multiply (op 110); otherwise op 110
//                is a NOP and busy is tied low.
//  Revision    : 1.0 - initial release
// ============================================================================
module accumulator_unit #(
  parameter int n = 8
) (
  input wire logic clk,
  input wire logic clearN,
  acc_if.slave     bus
);
  import acc_pkg::*;

  logic [n-1:0] a_q;
  logic         carry_q;
  logic         ovf_q;
  logic         done_q;

  logic [n-1:0] a_d;
  logic         carry_d;
  logic         ovf_d;
  logic [n:0]   sum_w;
  logic [n:0]   diff_w;

  // Single-cycle result and flags for the requested op
  always_comb begin
    sum_w   = {1'b0, a_q} + {1'b0, bus.IROut};
    diff_w  = {1'b0, a_q} - {1'b0, bus.IROut};
    a_d     = a_q;
    carry_d = carry_q;
    ovf_d   = ovf_q;
    case (bus.op)
      ACC_LDIN: begin
        a_d = bus.Input; carry_d = 1'b0; ovf_d = 1'b0;
      end
      ACC_LDIR: begin
        a_d = bus.IROut; carry_d = 1'b0; ovf_d = 1'b0;
      end
      ACC_CLR: begin
        a_d = '0; carry_d = 1'b0; ovf_d = 1'b0;
      end
      ACC_ADD: begin
        a_d     = sum_w[n-1:0];
        carry_d = sum_w[n];
        ovf_d   = ~(a_q[n-1] ^ bus.IROut[n-1]) & (sum_w[n-1] ^ a_q[n-1]);
      end
      ACC_SUB: begin
        a_d     = diff_w[n-1:0];
        carry_d = ~diff_w[n];
        ovf_d   = (a_q[n-1] ^ bus.IROut[n-1]) & (diff_w[n-1] ^ a_q[n-1]);
      end
      // NOP, reserved and (in this block) MUL leave A and flags alone
      default: begin
      end
    endcase
  end

`ifdef ACC_MUL_EN
  acc_state_e   state_q;
  logic         busy_q;
  logic         mul_start;
  logic [n-1:0] mul_prod;
  logic         mul_hi_nz;
  logic         mul_fin;

  assign mul_start = (state_q == S_IDLE) && bus.start && (bus.op == ACC_MUL);

  acc_shift_mul #(.n(n)) u_mul (
    .clk     (clk),
    .clearN  (clearN),
    .start_i (mul_start),
    .mcand_i (a_q),
    .mplr_i  (bus.IROut),
    .prod_o  (mul_prod),
    .hi_nz_o (mul_hi_nz),
    .fin_o   (mul_fin)
  );

  // Handshake FSM: single-cycle ops stay in IDLE, MUL waits for the multiplier
  always_ff @(posedge clk) begin
    if (!clearN) begin
      state_q <= S_IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      a_q     <= '0;
      carry_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (state_q == S_IDLE) begin
        if (bus.start) begin
          if (bus.op == ACC_MUL) begin
            state_q <= S_MUL;
            busy_q  <= 1'b1;
          end else begin
            a_q     <= a_d;
            carry_q <= carry_d;
            ovf_q   <= ovf_d;
            done_q  <= 1'b1;
          end
        end
      end else if (mul_fin) begin
        a_q     <= mul_prod;
        carry_q <= mul_hi_nz;
        ovf_q   <= mul_hi_nz;
        busy_q  <= 1'b0;
        done_q  <= 1'b1;
        state_q <= S_IDLE;
      end
    end
  end

  assign bus.busy = busy_q;
`else
  // Every op completes in one cycle; there is never anything to wait for
  always_ff @(posedge clk) begin
    if (!clearN) begin
      done_q  <= 1'b0;
      a_q     <= '0;
      carry_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      done_q <= bus.start;
      if (bus.start) begin
        a_q     <= a_d;
        carry_q <= carry_d;
        ovf_q   <= ovf_d;
      end
    end
  end

  assign bus.busy = 1'b0;
`endif

  assign bus.regAOut = a_q;
  assign bus.done    = done_q;
  assign bus.carry   = carry_q;
  assign bus.ovf     = ovf_q;
  assign bus.Aeq0    = (a_q == '0);
  assign bus.Apos    = ~a_q[n-1];

endmodule
`default_nettype wire

// File: doc/accumulator_unit.md
# accumulator_unit

Parametrised accumulator datapath for the processor core and successor to the fixed 8-bit accumulator block. It holds register A, executes load/clear/add/subtract operations in one cycle and, optionally, a multi-cycle shift-add multiply. It exposes registered carry/overflow flags and combinational zero/sign flags. The controller drives it through a start/busy/done handshake instead of raw mux-select and load strobes.

## Interface
- `n`, default 8: datapath width in bits, ≥ 2.
- `clk` in 1: rising-edge clock.
- `clearN` in 1: synchronous, active-low reset.
- `start` in 1: operation request; accepted only when `busy`=0.
- `op` in 3: operation code, sampled with an accepted `start`.
- `IROut` in n: operand from the instruction register.
- `Input` in n: external input port.
- `regAOut` out n: register A.
- `busy` out 1: a multi-cycle operation is in progress.
- `done` out 1: one-cycle pulse marking the cycle in which the result is visible on `regAOut`.
- `carry` out 1: registered carry / no-borrow flag.
- `ovf` out 1: registered overflow flag.
- `Aeq0` out 1: combinational, `regAOut`==0.
- `Apos` out 1: combinational, `~regAOut[n-1]` (zero counts as positive).

## Operation
Op codes:
- 000 NOP: A unchanged.
- 001 LDIN: A ← `Input`.
- 010 LDIR: A ← `IROut`.
- 011 CLR: A ← 0.
- 100 ADD: A ← A+`IROut` mod 2^n.
- 101 SUB: A ← A−`IROut` mod 2^n.
- 110 MUL: A ← low n bits of A×`IROut`, unsigned.
- 111: reserved; behaves as NOP.

Flags:
- ADD: `carry` = bit n of the (n+1)-bit sum; `ovf` = signed overflow (operands share a sign and the result sign differs).
- SUB: `carry` = 1 when A ≥ `IROut` unsigned (no borrow); `ovf` = signed overflow of A−`IROut`.
- MUL: `carry` = `ovf` = 1 when the high n bits of the 2n-bit product are nonzero.
- LDIN, LDIR, CLR: `carry` and `ovf` cleared to 0.
- NOP and reserved: flags unchanged.

FSM:
- States are IDLE and MUL. Single-cycle ops never leave IDLE.
- IDLE to MUL on an accepted `start` with `op`=110.
- In MUL, the operand (`IROut`) and multiplicand (A) are latched internally and a counter is loaded with n−1. Each cycle processes one multiplier bit into a 2n-bit partial product. When the counter reaches 0, the FSM writes A and the flags and returns to IDLE.

Reset:
- `clearN`=0 at a rising edge sets A=0, `carry`=0, `ovf`=0, `busy`=0, `done`=0, the FSM to IDLE and the counter to 0.
- Reset during MUL aborts the operation. No `done` is produced and the partial result is discarded.

## Timing
- Single-cycle op: accepted at edge k. A and flags update at edge k and `done`=1 for the cycle after edge k. `busy` stays 0. Back-to-back `start` on consecutive cycles is legal.
- MUL: accepted at edge k. `busy`=1 from edge k through edge k+n−1. A and flags update at edge k+n, `busy` falls and `done`=1 for one cycle. Total latency is n cycles.
- `start` while `busy`=1 is ignored: no queueing, no `done`, no error.
- `start` may be asserted in the same cycle `done` is high if `busy`=0. It is accepted normally.
- A and the flags never change without an accepted operation. `IROut` and `Input` changes outside an accepted `start` have no effect.
- `Aeq0` and `Apos` follow `regAOut` combinationally with no added latency.

## Configuration
- `ACC_MUL_EN` defined: MUL (110) is implemented as above, including the MUL state, counter and shift-add datapath.
- `ACC_MUL_EN` not defined:
  - 110 behaves as NOP: single-cycle `done`, A and flags unchanged.
  - `busy` is tied to 0.
  - No multiply hardware is synthesised.

## Structure
- Shared package `acc_pkg`: op-code constants (`ACC_NOP` through `ACC_RSV`) and the FSM state encoding.
- One sub-module, `acc_shift_mul`. It is parametrised on n, owns the counter and the 2n-bit partial product, takes start/operands and returns product/high-nonzero/finish. It is instantiated only under `ACC_MUL_EN`.
- The top level holds register A, the flag registers, the add/sub logic and the handshake.

## Test plan
- Reset: drive `clearN`=0 for 2 cycles → A=0, `Aeq0`=1, `Apos`=1, `carry`=`ovf`=`busy`=`done`=0.
- n=8: LDIN 0x7F, then ADD with `IROut`=0x01 → A=0x80, `ovf`=1, `carry`=0, `Apos`=0, one `done` per op.
- n=8: LDIR 0x05, then SUB with `IROut`=0x07 → A=0xFE, `carry`=0. Then SUB with `IROut`=0xFE → A=0x00, `carry`=1, `Aeq0`=1.
- MUL with `ACC_MUL_EN` defined, n=8:
  - A=0x0C, `IROut`=0x0B → `busy` for 8 cycles, then A=0x84, `carry`=0, `done` pulses once.
  - A=0x10, `IROut`=0x10 → A=0x00, `carry`=`ovf`=1.
  - A `start` asserted mid-`busy` is ignored.
- Reset asserted in cycle 3 of a MUL → A=0, `busy`=0, no `done`. The next LDIN 0x33 completes normally.
- Build without `ACC_MUL_EN`: op 110 with A=0x0C → `done` next cycle, `busy` never 1, A=0x0C.
